// File: rtl/if_chain_seq_unit.sv
// Sequential two-stage compare/if-else arithmetic chain behind valid/ready handshakes.
// Latency: 1 edge after accept for unequal or zero operands; 1+NT edges when the divide path runs.
// Backpressure: IN_READY only in IDLE; the result is held in DONE until OUT_READY is seen.
// Optional build macro IF_CHAIN_STATS_EN adds per-compare-class 16-bit result counters.
module if_chain_seq_unit #(
   parameter int NA   = 8,
   parameter int NB   = 16,
   parameter int NT   = 8,
   parameter int NOUT = 16
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [NA-1:0]   A,
   input  logic [NB-1:0]   B,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [NOUT-1:0] XOUT
`ifdef IF_CHAIN_STATS_EN
   ,
   output logic [15:0]     CNT_GT,
   output logic [15:0]     CNT_LT,
   output logic [15:0]     CNT_EQ
`endif
);

   // Compare width, stage-1 subtract width, product width, step counter width
   localparam int NM = (NA > NB) ? NA : NB;
   localparam int NW = (NB > NT) ? NB : NT;
   localparam int NP = NT + NB;
   localparam int CW = $clog2(NT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]      r_state;
   logic [NA-1:0]   r_a;
   logic [NB-1:0]   r_b;
   logic [NOUT-1:0] r_xout;
   logic            r_out_valid;
   logic [NA-1:0]   r_rem;
   logic [NT-1:0]   r_quo;
   logic [CW-1:0]   r_cnt;

   logic [NM-1:0]   w_am;
   logic [NM-1:0]   w_bm;
   logic            w_gt;
   logic            w_lt;
   logic            w_eq;
   logic [NT-1:0]   w_t;
   logic [NT-1:0]   w_a_t;
   logic [NW-1:0]   w_diff;
   logic [NP-1:0]   w_prod;
   logic [NT-1:0]   w_t1;
   logic [NT-1:0]   w_res_nd;
   logic [NA:0]     w_trial;
   logic            w_ge;
   logic [NA-1:0]   w_rem_nx;
   logic [NT-1:0]   w_quo_nx;
   logic [NT-1:0]   w_quo_p1;
   logic            w_div_last;

   assign IN_READY  = (r_state == S_IDLE);
   assign OUT_VALID = r_out_valid;
   assign XOUT      = r_xout;

   // Unsigned compare of the captured operands at a common width
   assign w_am = NM'(r_a);
   assign w_bm = NM'(r_b);
   assign w_gt = (w_am > w_bm);
   assign w_lt = (w_am < w_bm);
   assign w_eq = (w_am == w_bm);

   assign w_t    = NT'(r_b);
   assign w_a_t  = NT'(r_a);
   assign w_diff = NW'(w_t) - NW'(r_b);
   assign w_prod = NP'(w_t) * NP'(r_b);

   // Stage 1 and the non-divide stage 2, all modulo 2^NT
   always_comb begin
      w_t1     = '0;
      w_res_nd = '0;
      if (w_gt) begin
         w_t1     = w_t + w_a_t;
         w_res_nd = w_t1 - w_a_t;
      end else if (w_lt) begin
         w_t1     = NT'(w_diff);
         w_res_nd = w_t1 + w_a_t;
      end else begin
         w_t1     = NT'(w_prod);
         w_res_nd = w_t1 + w_a_t;
      end
   end

   // Restoring divide step: r_quo shifts dividend bits out and quotient bits in
   assign w_trial    = {r_rem, r_quo[NT-1]};
   assign w_ge       = (w_trial >= {1'b0, r_a});
   assign w_rem_nx   = w_ge ? NA'(w_trial - {1'b0, r_a}) : w_trial[NA-1:0];
   assign w_quo_nx   = {r_quo[NT-2:0], w_ge};
   assign w_quo_p1   = w_quo_nx + NT'(1);
   assign w_div_last = (r_state == S_DIV) && (r_cnt == CW'(NT - 1));

   // Control FSM, operand capture, divider and result register
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_xout      <= '0;
         r_out_valid <= 1'b0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (IN_VALID) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               if (!w_eq) begin
                  r_xout      <= NOUT'(w_res_nd);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else if (r_a == '0) begin
                  // Divide by zero: quotient all ones, plus one wraps to zero
                  r_xout      <= '0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_rem   <= '0;
                  r_quo   <= w_t1;
                  r_cnt   <= '0;
                  r_state <= S_DIV;
               end
            end
            S_DIV: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               r_cnt <= r_cnt + CW'(1);
               if (w_div_last) begin
                  r_xout      <= NOUT'(w_quo_p1);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (OUT_READY) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef IF_CHAIN_STATS_EN
   logic [15:0] r_cnt_gt;
   logic [15:0] r_cnt_lt;
   logic [15:0] r_cnt_eq;
   logic        w_inc_gt;
   logic        w_inc_lt;
   logic        w_inc_eq;

   assign w_inc_gt = (r_state == S_CALC) && w_gt;
   assign w_inc_lt = (r_state == S_CALC) && w_lt;
   assign w_inc_eq = ((r_state == S_CALC) && w_eq && (r_a == '0)) || w_div_last;

   assign CNT_GT = r_cnt_gt;
   assign CNT_LT = r_cnt_lt;
   assign CNT_EQ = r_cnt_eq;

   // Per-class result counters, bumped on the edge that loads XOUT
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt_gt <= '0;
         r_cnt_lt <= '0;
         r_cnt_eq <= '0;
      end else begin
         if (w_inc_gt) r_cnt_gt <= r_cnt_gt + 16'd1;
         if (w_inc_lt) r_cnt_lt <= r_cnt_lt + 16'd1;
         if (w_inc_eq) r_cnt_eq <= r_cnt_eq + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_chain_seq_unit.sv
// Scoreboard bench for if_chain_seq_unit: stimulus pushes expected results, monitor checks outputs.
// Latency checked from accept edge to OUT_VALID rise; XOUT checked on every valid cycle.
// Backpressure exercised by holding OUT_READY low and pulsing IN_VALID during DONE.
module tb_if_chain_seq_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IN_VALID;
   logic        IN_READY;
   logic [7:0]  A;
   logic [15:0] B;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [15:0] XOUT;
`ifdef IF_CHAIN_STATS_EN
   logic [15:0] CNT_GT;
   logic [15:0] CNT_LT;
   logic [15:0] CNT_EQ;
`endif

   if_chain_seq_unit #(.NA(8), .NB(16), .NT(8), .NOUT(16)) dut (
      .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .XOUT(XOUT)
`ifdef IF_CHAIN_STATS_EN
      , .CNT_GT(CNT_GT), .CNT_LT(CNT_LT), .CNT_EQ(CNT_EQ)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] xout;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_acc;
   int   hs;
   logic prev_vld = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: latency at the rising edge of OUT_VALID, value and IN_READY while valid
   always @(negedge CLK) begin
      if (!RST && OUT_VALID) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", {16'h0, XOUT}, 32'hFFFF_FFFF);
         end else begin
            if (!prev_vld) chk("latency", cyc - sb[0].acc, sb[0].lat);
            chk("xout", {16'h0, XOUT}, {16'h0, sb[0].xout});
            chk("in_ready_busy", {31'h0, IN_READY}, 32'h0);
         end
      end
      prev_vld = OUT_VALID;
   end

   // Retire the expectation on the output handshake edge
   always @(posedge CLK) begin
      if (!RST && OUT_VALID && OUT_READY && sb.size() != 0) void'(sb.pop_front());
   end

   // Called at a negedge; holds IN_VALID until accepted, returns at the negedge after accept
   task automatic send(input logic [7:0] a, input logic [15:0] b,
                       input logic [15:0] x, input int lat);
      bit ok = 0;
      A = a;
      B = b;
      IN_VALID = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (IN_READY) begin
            sb.push_back('{x, lat, cyc + 1});
            last_acc = cyc + 1;
            ok = 1;
            @(posedge CLK);
         end
         @(negedge CLK);
      end
      IN_VALID = 1'b0;
      if (!ok) chk("accept_timeout", 32'h0, 32'h1);
      else chk("in_ready_after_accept", {31'h0, IN_READY}, 32'h0);
   endtask

   task automatic drain();
      bit done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
         if (sb.size() == 0 && !OUT_VALID) done = 1;
         else @(negedge CLK);
      end
      if (!done) chk("drain_timeout", 32'h0, 32'h1);
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [15:0] b;
      logic [15:0] x;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      RST = 1'b1;
      IN_VALID = 1'b0;
      A = '0;
      B = '0;
      OUT_READY = 1'b1;
      repeat (3) @(negedge CLK);
      chk("rst_out_valid", {31'h0, OUT_VALID}, 32'h0);
      chk("rst_xout", {16'h0, XOUT}, 32'h0);
      chk("rst_in_ready", {31'h0, IN_READY}, 32'h1);
      RST = 1'b0;
      @(negedge CLK);

      // Hand-computed: A>B -> t+A-A; A<B -> 0+A; A==B -> (t*t mod 256)/A + 1
      vecs.push_back('{8'd5,   16'd3,      16'd3,   1});
      vecs.push_back('{8'd3,   16'h0105,   16'd3,   1});
      vecs.push_back('{8'd7,   16'd7,      16'd8,   9});
      vecs.push_back('{8'd0,   16'd0,      16'd0,   1});
      vecs.push_back('{8'd200, 16'd100,    16'd100, 1});
      vecs.push_back('{8'd10,  16'd10,     16'd11,  9});
      vecs.push_back('{8'd255, 16'd255,    16'd1,   9});
      vecs.push_back('{8'd9,   16'h0300,   16'd9,   1});
      vecs.push_back('{8'd255, 16'd0,      16'd0,   1});
      foreach (vecs[i]) begin
         send(vecs[i].a, vecs[i].b, vecs[i].x, vecs[i].lat);
         drain();
         chk("xout_retained", {16'h0, XOUT}, {16'h0, vecs[i].x});
      end

      // Backpressure: result held, IN_VALID pulses ignored, next accept the cycle after
      OUT_READY = 1'b0;
      send(8'd5, 16'd3, 16'd3, 1);
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         A = 8'd9;
         B = 16'd1;
         IN_VALID = i[0];
      end
      IN_VALID = 1'b0;
      chk("held_valid", {31'h0, OUT_VALID}, 32'h1);
      OUT_READY = 1'b1;
      hs = cyc + 1;
      send(8'd2, 16'd9, 16'd2, 1);
      chk("accept_after_hs", last_acc - hs, 1);
      drain();

      // Reset during the 4th divide step aborts without output
      send(8'd7, 16'd7, 16'd8, 9);
      repeat (4) @(negedge CLK);
      RST = 1'b1;
      sb.delete();
      @(negedge CLK);
      chk("abort_out_valid", {31'h0, OUT_VALID}, 32'h0);
      chk("abort_xout", {16'h0, XOUT}, 32'h0);
      chk("abort_in_ready", {31'h0, IN_READY}, 32'h1);
`ifdef IF_CHAIN_STATS_EN
      chk("abort_cnt_gt", {16'h0, CNT_GT}, 32'h0);
      chk("abort_cnt_lt", {16'h0, CNT_LT}, 32'h0);
      chk("abort_cnt_eq", {16'h0, CNT_EQ}, 32'h0);
`endif
      RST = 1'b0;
      @(negedge CLK);
      send(8'd5, 16'd3, 16'd3, 1);
      drain();
      chk("post_abort_xout", {16'h0, XOUT}, 32'd3);
`ifdef IF_CHAIN_STATS_EN
      chk("post_cnt_gt", {16'h0, CNT_GT}, 32'h1);
      chk("post_cnt_lt", {16'h0, CNT_LT}, 32'h0);
      chk("post_cnt_eq", {16'h0, CNT_EQ}, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
